// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, controller states and
// per-opcode hold time.
package alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00100;
    localparam logic [4:0] OP_OR  = 5'b00101;
    localparam logic [4:0] OP_NOT = 5'b00110;
    localparam logic [4:0] OP_FFT = 5'b00111;
    localparam logic [4:0] OP_ENC = 5'b01000;
    localparam logic [4:0] OP_DEC = 5'b01001;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    function automatic logic op_reserved(input logic [4:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND,
            OP_OR, OP_NOT, OP_FFT, OP_ENC, OP_DEC: r = 1'b0;
            default:                               r = 1'b1;
        endcase
        return r;
    endfunction

    // Number of cycles the ALU inputs stay registered before the result is sampled.
    function automatic int unsigned op_hold_cycles(input logic [4:0] op,
                                                   input int unsigned mul_lat,
                                                   input int unsigned div_lat);
        int unsigned l;
        case (op)
            OP_MUL:  l = mul_lat;
            OP_DIV:  l = div_lat;
            default: l = 1;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module alu_rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one combinational ALU between the core (port 0) and the coprocessor (port 1),
// holding operands for multicycle ops and returning results over valid/ready.
module alu_arbiter_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 19,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [4:0]       req_op0,
    input  logic [4:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_neg,
    output logic             rsp_err,
    output logic             busy
);

    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [4:0]        alu_ctrl_q, alu_ctrl_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_neg_q, rsp_neg_d;
    logic              rsp_err_q, rsp_err_d;

    logic [1:0]        grant;
    logic [4:0]        sel_op;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic              reserved;

    alu_rr_arb2 u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign sel_op   = grant[1] ? req_op1 : req_op0;
    assign sel_a    = grant[1] ? req_a1  : req_a0;
    assign sel_b    = grant[1] ? req_b1  : req_b0;
    assign reserved = op_reserved(alu_ctrl_q);

    // Combinational valid->ready; only offered while idle.
    assign req_ready = (state_q == StIdle) ? (req_valid & grant) : 2'b00;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_neg_d    = rsp_neg_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            StIdle: begin
                if (|req_ready) begin
                    owner_d      = grant[1];
                    last_grant_d = grant[1];
                    alu_ctrl_d   = sel_op;
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    cnt_d        = CntW'(op_hold_cycles(sel_op, MUL_LAT, DIV_LAT) - 1);
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    // Reserved opcodes report an error with a clean zero result.
                    rsp_data_d  = reserved ? '0 : alu_result;
                    rsp_neg_d   = reserved ? 1'b0 : alu_negative;
                    rsp_err_d   = reserved | ((alu_ctrl_q == OP_DIV) && (alu_b_q == '0));
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
            rsp_neg_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_neg_q    <= rsp_neg_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_neg   = rsp_neg_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Scoreboard bench for alu_arbiter_ctrl: directed ops push expected responses, a negedge
// monitor checks grants, hold time, operand stability and responses.
module tb_alu_arbiter_ctrl;
    import alu_pkg::*;

    localparam int unsigned W = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid, req_ready;
    logic [4:0]    req_op0, req_op1;
    logic [W-1:0]  req_a0, req_a1, req_b0, req_b1;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [4:0]    alu_ctrl;
    logic          alu_negative;
    logic [1:0]    rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_data;
    logic          rsp_neg, rsp_err, busy;

    always #5 clk = ~clk;

    alu_arbiter_ctrl #(
        .WIDTH   (W),
        .MUL_LAT (2),
        .DIV_LAT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .req_a0       (req_a0),
        .req_a1       (req_a1),
        .req_b0       (req_b0),
        .req_b1       (req_b1),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_negative (alu_negative),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_neg      (rsp_neg),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    // Stand-in ALU; unknown opcodes give all-ones so result forcing is observable.
    always_comb begin
        case (alu_ctrl)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_MUL:  alu_result = alu_a * alu_b;
            OP_DIV:  alu_result = (alu_b == '0) ? '0 : alu_a / alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_NOT:  alu_result = ~alu_a;
            default: alu_result = '1;
        endcase
        alu_negative = alu_result[W-1];
    end

    typedef struct {
        int           owner;
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] data;
        logic         neg;
        logic         err;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t tv[8];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    bit   stable   = 1'b1;
    bit   prev_valid = 1'b0;

    function automatic exp_t mk(int owner, logic [4:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                logic [W-1:0] data, logic neg, logic err, int lat);
        exp_t e;
        e.owner = owner; e.op = op; e.a = a; e.b = b;
        e.data = data; e.neg = neg; e.err = err; e.lat = lat;
        return e;
    endfunction

    function automatic logic [1:0] onehot(int p);
        return (p == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic drive(input int p, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        if (p == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
        end
    endtask

    task automatic drop(input int p);
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_accept(input int p, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!req_ready[p] && waited < 200);
        if (!req_ready[p]) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy == 1'b0 && rsp_valid == 2'b00 && exp_q.size() == 0) && n < 200);
        if (n >= 200) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input exp_t e);
        int w;
        exp_q.push_back(e);
        @(posedge clk); #1;
        drive(e.owner, e.op, e.a, e.b);
        wait_accept(e.owner, w);
        @(posedge clk); #1;
        drop(e.owner);
        wait_idle();
    endtask

    task automatic port_seq(input int p, input int first);
        int w;
        @(posedge clk); #1;
        for (int k = first; k < 8; k += 2) begin
            drive(p, tv[k].op, tv[k].a, tv[k].b);
            wait_accept(p, w);
            @(posedge clk); #1;
        end
        drop(p);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: grants, operand hold, response content and latency, backpressure stability.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (req_ready != 2'b00 && exp_q.size() > 0) begin
                check("grant", {30'd0, req_ready}, {30'd0, onehot(exp_q[0].owner)});
                acc_cyc = cyc;
                stable  = 1'b1;
            end
            if (busy && rsp_valid == 2'b00 && exp_q.size() > 0) begin
                if ({alu_ctrl, alu_a, alu_b} !== {exp_q[0].op, exp_q[0].a, exp_q[0].b})
                    stable = 1'b0;
            end
            if (rsp_valid != 2'b00 && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", {30'd0, rsp_valid}, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("rsp_owner", {30'd0, rsp_valid}, {30'd0, onehot(cur.owner)});
                    check("rsp_data", {13'd0, rsp_data}, {13'd0, cur.data});
                    check("rsp_neg", {31'd0, rsp_neg}, {31'd0, cur.neg});
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
                    check("latency", cyc - acc_cyc - 1, cur.lat);
                    check("alu_hold", {31'd0, stable}, 32'd1);
                end
            end else if (rsp_valid != 2'b00) begin
                check("held_valid", {30'd0, rsp_valid}, {30'd0, onehot(cur.owner)});
                check("held_data", {13'd0, rsp_data}, {13'd0, cur.data});
                check("held_busy", {31'd0, busy}, 32'd1);
                check("held_no_ready", {30'd0, req_ready}, 32'd0);
            end
            prev_valid = (rsp_valid != 2'b00);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("reset_req_ready", {30'd0, req_ready}, 32'd0);
        check("reset_alu_ctrl", {27'd0, alu_ctrl}, 32'd0);
        check("reset_alu_a", {13'd0, alu_a}, 32'd0);
        check("reset_alu_b", {13'd0, alu_b}, 32'd0);
        check("reset_rsp_data", {13'd0, rsp_data}, 32'd0);
        check("reset_rsp_flags", {30'd0, rsp_neg, rsp_err}, 32'd0);

        // Single ADD on port 0.
        issue(mk(0, OP_ADD, 19'd5, 19'd7, 19'd12, 1'b0, 1'b0, 1));

        // Both ports continuously valid; port 0 was granted last, so port 1 leads.
        tv[0] = mk(1, OP_ADD, 19'd100, 19'd200, 19'd300, 1'b0, 1'b0, 1);
        tv[1] = mk(0, OP_ADD, 19'd1, 19'd2, 19'd3, 1'b0, 1'b0, 1);
        tv[2] = mk(1, OP_MUL, 19'd3, 19'd5, 19'd15, 1'b0, 1'b0, 2);
        tv[3] = mk(0, OP_SUB, 19'd10, 19'd3, 19'd7, 1'b0, 1'b0, 1);
        tv[4] = mk(1, OP_NOT, 19'd0, 19'd0, 19'h7FFFF, 1'b1, 1'b0, 1);
        tv[5] = mk(0, OP_AND, 19'd12, 19'd10, 19'd8, 1'b0, 1'b0, 1);
        tv[6] = mk(1, OP_SUB, 19'd5, 19'd5, 19'd0, 1'b0, 1'b0, 1);
        tv[7] = mk(0, OP_OR, 19'd12, 19'd3, 19'd15, 1'b0, 1'b0, 1);
        for (int i = 0; i < 8; i++) exp_q.push_back(tv[i]);
        fork
            port_seq(1, 0);
            port_seq(0, 1);
        join
        wait_idle();

        // Multicycle, divide-by-zero, reserved opcode, negative wrap.
        issue(mk(1, OP_DIV, 19'd100, 19'd0, 19'd0, 1'b0, 1'b1, 4));
        issue(mk(0, OP_DIV, 19'd100, 19'd7, 19'd14, 1'b0, 1'b0, 4));
        issue(mk(0, OP_MUL, 19'd3, 19'd4, 19'd12, 1'b0, 1'b0, 2));
        issue(mk(1, 5'b01010, 19'd3, 19'd4, 19'd0, 1'b0, 1'b1, 1));
        issue(mk(1, OP_SUB, 19'd0, 19'd1, 19'h7FFFF, 1'b1, 1'b0, 1));

        // Backpressure with both requesters waiting.
        rsp_ready = 2'b00;
        exp_q.push_back(mk(0, OP_ADD, 19'd2, 19'd3, 19'd5, 1'b0, 1'b0, 1));
        exp_q.push_back(mk(1, OP_ADD, 19'd1, 19'd1, 19'd2, 1'b0, 1'b0, 1));
        exp_q.push_back(mk(0, OP_AND, 19'd6, 19'd3, 19'd2, 1'b0, 1'b0, 1));
        @(posedge clk); #1;
        drive(0, OP_ADD, 19'd2, 19'd3);
        wait_accept(0, w);
        @(posedge clk); #1;
        drive(0, OP_AND, 19'd6, 19'd3);
        drive(1, OP_ADD, 19'd1, 19'd1);
        repeat (6) @(posedge clk);
        #1 rsp_ready = 2'b11;
        wait_accept(1, w);
        check("release_to_idle", w, 2);
        check("release_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        drop(1);
        wait_accept(0, w);
        @(posedge clk); #1;
        drop(0);
        wait_idle();

        // Reset in the middle of a DIV on port 0: no response, tie then goes to port 0.
        @(posedge clk); #1;
        drive(0, OP_DIV, 19'd50, 19'd5);
        wait_accept(0, w);
        @(posedge clk); #1;
        drop(0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("midrst_alu", {8'd0, alu_ctrl, alu_a}, 32'd0);
        check("midrst_alu_b", {13'd0, alu_b}, 32'd0);
        check("midrst_rsp", {11'd0, rsp_data, rsp_neg, rsp_err}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.push_back(mk(0, OP_ADD, 19'd8, 19'd8, 19'd16, 1'b0, 1'b0, 1));
        exp_q.push_back(mk(1, OP_SUB, 19'd9, 19'd4, 19'd5, 1'b0, 1'b0, 1));
        @(posedge clk); #1;
        drive(0, OP_ADD, 19'd8, 19'd8);
        drive(1, OP_SUB, 19'd9, 19'd4);
        wait_accept(0, w);
        @(posedge clk); #1;
        drop(0);
        wait_accept(1, w);
        @(posedge clk); #1;
        drop(1);
        wait_idle();
        repeat (10) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
